// File: rtl/bitset_seq.sv
// Bit-vector register with single-cycle bit ops and a multi-cycle circular scan
// that finds the first position at or after a start index holding a given value.
module bitset_seq #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned IDXW  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [IDXW-1:0]  cmd_index,
    input  logic             cmd_value,
    input  logic [WIDTH-1:0] cmd_data,
    output logic [WIDTH-1:0] bits,
    output logic             scan_done,
    output logic             scan_found,
    output logic [IDXW-1:0]  scan_index
);

    localparam logic [2:0] OpNop    = 3'b000;
    localparam logic [2:0] OpWrite  = 3'b001;
    localparam logic [2:0] OpToggle = 3'b010;
    localparam logic [2:0] OpLoad   = 3'b011;
    localparam logic [2:0] OpClear  = 3'b100;
    localparam logic [2:0] OpScan   = 3'b101;

    localparam logic [IDXW:0] CntMax = (IDXW+1)'(WIDTH);

    typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  bits_q, bits_d;
    logic [IDXW-1:0]   start_q;
    logic              value_q;
    logic [IDXW-1:0]   pos_q;
    logic [IDXW:0]     cnt_q;
    logic              cmp_valid_q;
    logic              cmp_hit_q;
    logic [IDXW-1:0]   cmp_pos_q;
    logic              found_q;
    logic [IDXW-1:0]   index_q;

    logic accept;
    logic scan_start;
    logic scan_hit;
    logic scan_miss;
    logic scan_end;
    logic examine;

    assign accept     = cmd_valid & cmd_ready;
    assign scan_start = accept && (cmd_op == OpScan);
    // Compare results are registered, so the decision lags the examined position by one cycle.
    assign scan_hit   = (state_q == StScan) && cmp_valid_q && cmp_hit_q;
    assign scan_miss  = (state_q == StScan) && !scan_hit && (cnt_q == CntMax);
    assign scan_end   = scan_hit | scan_miss;
    assign examine    = (state_q == StScan) && !scan_end;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (scan_start) state_d = StScan;
            StScan:  if (scan_end)   state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs
    always_comb begin
        cmd_ready = (state_q == StIdle);
        scan_done = (state_q == StDone);
    end

    always_comb begin
        bits_d = bits_q;
        if (accept) begin
            case (cmd_op)
                OpWrite:  bits_d[cmd_index] = cmd_value;
                OpToggle: bits_d[cmd_index] = ~bits_q[cmd_index];
                OpLoad:   bits_d = cmd_data;
                OpClear:  bits_d = '0;
                default:  bits_d = bits_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bits_q      <= '0;
            start_q     <= '0;
            value_q     <= 1'b0;
            pos_q       <= '0;
            cnt_q       <= '0;
            cmp_valid_q <= 1'b0;
            cmp_hit_q   <= 1'b0;
            cmp_pos_q   <= '0;
            found_q     <= 1'b0;
            index_q     <= '0;
        end else begin
            bits_q <= bits_d;
            if (scan_start) begin
                start_q     <= cmd_index;
                value_q     <= cmd_value;
                pos_q       <= cmd_index;
                cnt_q       <= '0;
                cmp_valid_q <= 1'b0;
            end else if (examine) begin
                cmp_valid_q <= 1'b1;
                cmp_hit_q   <= (bits_q[pos_q] == value_q);
                cmp_pos_q   <= pos_q;
                // WIDTH is a power of two, so natural overflow gives the wrap to 0.
                pos_q       <= pos_q + IDXW'(1);
                cnt_q       <= cnt_q + (IDXW+1)'(1);
            end
            if (scan_hit) begin
                found_q <= 1'b1;
                index_q <= cmp_pos_q;
            end else if (scan_miss) begin
                found_q <= 1'b0;
                index_q <= start_q;
            end
        end
    end

    assign bits       = bits_q;
    assign scan_found = found_q;
    assign scan_index = index_q;

    logic unused_op;
    assign unused_op = (OpNop == 3'b000);

endmodule

// File: tb/tb_bitset_seq.sv
// Randomized self-checking bench for bitset_seq against a behavioural model of
// the bit register and of scan results and latency.
module tb_bitset_seq;

    localparam int W = 8;
    localparam int IW = 3;

    logic          clk;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_op;
    logic [IW-1:0] cmd_index;
    logic          cmd_value;
    logic [W-1:0]  cmd_data;
    logic [W-1:0]  bits;
    logic          scan_done;
    logic          scan_found;
    logic [IW-1:0] scan_index;

    int vectors;
    int miscompares;
    logic [W-1:0] mbits;

    bitset_seq #(.WIDTH(W), .IDXW(IW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_index  (cmd_index),
        .cmd_value  (cmd_value),
        .cmd_data   (cmd_data),
        .bits       (bits),
        .scan_done  (scan_done),
        .scan_found (scan_found),
        .scan_index (scan_index)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] model_apply(input logic [W-1:0] cur, input int op,
                                                 input int idx, input logic val,
                                                 input logic [W-1:0] data);
        logic [W-1:0] r;
        r = cur;
        case (op)
            1: r[idx] = val;
            2: r[idx] = ~cur[idx];
            3: r = data;
            4: r = '0;
            default: r = cur;
        endcase
        return r;
    endfunction

    // Single-cycle command: leaves cmd_valid high so consecutive calls are back-to-back.
    task automatic cmd(input int op, input int idx, input logic val, input logic [W-1:0] data);
        cmd_op    = 3'(op);
        cmd_index = IW'(idx);
        cmd_value = val;
        cmd_data  = data;
        cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mbits = model_apply(mbits, op, idx, val, data);
        check("bits_after_cmd", 32'(bits), 32'(mbits));
        check("ready_after_cmd", 32'(cmd_ready), 32'd1);
    endtask

    task automatic scan(input int s, input logic v, input bit hold_write);
        int exp_lat;
        int exp_idx;
        logic exp_found;
        int n;
        exp_found = 1'b0;
        exp_idx = s;
        exp_lat = W + 1;
        for (int k = 0; k < W; k++) begin
            if (mbits[(s + k) % W] == v) begin
                exp_found = 1'b1;
                exp_idx = (s + k) % W;
                exp_lat = k + 2;
                break;
            end
        end
        cmd_op    = 3'b101;
        cmd_index = IW'(s);
        cmd_value = v;
        cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (hold_write) begin
            cmd_op    = 3'b001;
            cmd_index = '0;
            cmd_value = 1'b1;
        end else begin
            cmd_valid = 1'b0;
        end
        n = 0;
        while (scan_done !== 1'b1 && n < W + 4) begin
            check("busy_ready", 32'(cmd_ready), 32'd0);
            check("busy_bits", 32'(bits), 32'(mbits));
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        check("scan_latency", 32'(n), 32'(exp_lat));
        check("scan_found", 32'(scan_found), 32'(exp_found));
        check("scan_index", 32'(scan_index), 32'(exp_idx));
        check("done_bits", 32'(bits), 32'(mbits));
        check("done_ready", 32'(cmd_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("idle_ready", 32'(cmd_ready), 32'd1);
        check("idle_done", 32'(scan_done), 32'd0);
        check("idle_bits", 32'(bits), 32'(mbits));
        check("hold_found", 32'(scan_found), 32'(exp_found));
        check("hold_index", 32'(scan_index), 32'(exp_idx));
        if (hold_write) begin
            @(posedge clk);
            @(negedge clk);
            cmd_valid = 1'b0;
            mbits[0] = 1'b1;
            check("held_write", 32'(bits), 32'(mbits));
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        mbits = '0;
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_op = '0;
        cmd_index = '0;
        cmd_value = 1'b0;
        cmd_data = '0;
        #1;
        check("rst_bits", 32'(bits), 32'd0);
        check("rst_ready", 32'(cmd_ready), 32'd1);
        check("rst_done", 32'(scan_done), 32'd0);
        check("rst_found", 32'(scan_found), 32'd0);
        check("rst_index", 32'(scan_index), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Bit ops, one update per consecutive cycle
        cmd(4, 0, 1'b0, '0);
        check("seq0", 32'(bits), 32'h00);
        cmd(1, 5, 1'b1, '0);
        check("seq1", 32'(bits), 32'h20);
        cmd(2, 0, 1'b0, '0);
        check("seq2", 32'(bits), 32'h21);
        cmd(1, 5, 1'b0, '0);
        check("seq3", 32'(bits), 32'h01);
        cmd_valid = 1'b0;

        // Load then scan; wrap-around; not found; busy ignore
        cmd(3, 0, 1'b0, 8'b0001_0100);
        scan(0, 1'b1, 1'b0);
        cmd(3, 0, 1'b0, 8'b0000_0010);
        scan(6, 1'b1, 1'b0);
        cmd(3, 0, 1'b0, 8'hFF);
        scan(3, 1'b0, 1'b0);
        cmd(3, 0, 1'b0, 8'b0100_0000);
        scan(2, 1'b1, 1'b1);
        cmd(7, 4, 1'b1, 8'hA5);
        cmd(6, 2, 1'b1, 8'h5A);
        cmd(0, 1, 1'b1, 8'h33);
        cmd_valid = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 80; i++) begin
            int op;
            logic [W-1:0] d;
            op = int'($urandom_range(0, 7));
            d = 8'($urandom);
            if ($urandom_range(0, 4) == 0) d = $urandom_range(0, 1) != 0 ? 8'hFF : 8'h00;
            if (op == 5) begin
                scan(int'($urandom_range(0, W - 1)), 1'($urandom), $urandom_range(0, 3) == 0);
            end else begin
                cmd(op, int'($urandom_range(0, W - 1)), 1'($urandom), d);
                if ($urandom_range(0, 2) == 0) begin
                    cmd_valid = 1'b0;
                    @(negedge clk);
                    check("idle_gap_bits", 32'(bits), 32'(mbits));
                end
            end
        end
        cmd_valid = 1'b0;

        // Reset mid-scan: leave a found result first so the clear is visible
        cmd(3, 0, 1'b0, 8'hFF);
        scan(0, 1'b1, 1'b0);
        cmd_op = 3'b101;
        cmd_index = 3'd1;
        cmd_value = 1'b0;
        cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        mbits = '0;
        check("mid_rst_bits", 32'(bits), 32'd0);
        check("mid_rst_ready", 32'(cmd_ready), 32'd1);
        check("mid_rst_done", 32'(scan_done), 32'd0);
        check("mid_rst_found", 32'(scan_found), 32'd0);
        check("mid_rst_index", 32'(scan_index), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_hold_done", 32'(scan_done), 32'd0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < W + 2; i++) begin
            @(negedge clk);
            check("post_rst_done", 32'(scan_done), 32'd0);
        end
        cmd(1, 3, 1'b1, '0);
        check("post_rst_write", 32'(bits), 32'h08);
        cmd_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bitset_seq.md
BITSET_SEQ -- requirements
Module: bitset_seq

Interface
REQ-001 Parameter: WIDTH, default 8, bit-vector width; SHALL be a power of two, minimum 2.
REQ-002 Parameter: IDXW, default log2(WIDTH) = 3, index width; SHALL equal log2(WIDTH).
REQ-003 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port: cmd_valid  input  1  command present.
REQ-006 Port: cmd_ready  output  1  block can accept a command.
REQ-007 Port: cmd_op  input  3  opcode, encoded as follows.
- 000 NOP
- 001 WRITE_BIT
- 010 TOGGLE_BIT
- 011 LOAD
- 100 CLEAR_ALL
- 101 SCAN
- 110 and 111 reserved
REQ-008 Port: cmd_index  input  IDXW  target bit index, or scan start index.
REQ-009 Port: cmd_value  input  1  value to write, or bit value to search for.
REQ-010 Port: cmd_data  input  WIDTH  full-vector load data.
REQ-011 Port: bits  output  WIDTH  current register contents.
REQ-012 Port: scan_done  output  1  one-cycle pulse at scan completion.
REQ-013 Port: scan_found  output  1  last scan found a match.
REQ-014 Port: scan_index  output  IDXW  result index of last scan.

Function
REQ-015 The block SHALL accept a command on a rising edge where cmd_valid=1 and cmd_ready=1; otherwise no command is accepted.
REQ-016 cmd_ready SHALL be 1 only in state IDLE; it SHALL be 0 in states SCAN and DONE.
REQ-017 WRITE_BIT SHALL set bits[cmd_index]=cmd_value and leave all other bits unchanged; the result SHALL be visible the cycle after acceptance.
REQ-018 TOGGLE_BIT SHALL invert bits[cmd_index] only; the result SHALL be visible the cycle after acceptance.
REQ-019 LOAD SHALL set bits=cmd_data, and CLEAR_ALL SHALL set bits=0; each SHALL be visible the cycle after acceptance.
REQ-020 NOP and the reserved opcodes SHALL be accepted and SHALL change no state.
REQ-021 Single-cycle ops SHALL keep the FSM in IDLE, so that back-to-back commands are accepted every cycle.
REQ-022 FSM states SHALL be IDLE, SCAN and DONE.
- IDLE to SCAN on an accepted SCAN command.
- SCAN to DONE on a match, or after WIDTH positions are examined.
- DONE to IDLE unconditionally after one cycle.
REQ-023 On SCAN acceptance, the block SHALL latch the start index s=cmd_index and the search value v=cmd_value, and SHALL clear its position count.
REQ-024 In SCAN, the block SHALL examine one position p per cycle, starting at p=s; p SHALL advance as p=(p+1) mod WIDTH, wrapping from WIDTH-1 to 0.
REQ-025 A match is bits[p]==v; on a match the block SHALL record scan_found=1 and scan_index=p, then enter DONE.
REQ-026 If no match is found after exactly WIDTH positions, the block SHALL record scan_found=0 and scan_index=s, then enter DONE.
REQ-027 scan_done SHALL be 1 exactly in the DONE cycle.
REQ-028 Scan latency SHALL be fixed: a match at distance k=(p-s) mod WIDTH SHALL give scan_done k+2 cycles after the acceptance edge, and no match SHALL give WIDTH+1 cycles.
REQ-029 scan_found and scan_index SHALL hold their values until the next scan completes.
REQ-030 bits SHALL NOT change during SCAN or DONE, because no command is accepted in those states.
REQ-031 Commands presented while cmd_ready=0 SHALL be ignored and SHALL have no side effect; the requester keeps cmd_valid asserted until acceptance.

Reset
REQ-032 rst_n=0 SHALL immediately, without waiting for clk, force the following values.
- bits=0
- FSM state IDLE
- scan_done=0
- scan_found=0
- scan_index=0
- internal counters 0
REQ-033 During reset, cmd_ready SHALL be 1, reflecting state IDLE.
REQ-034 Reset asserted mid-scan SHALL abort the scan with no scan_done pulse, and SHALL leave scan_found and scan_index at 0.
REQ-035 After rst_n is released, the first rising edge SHALL be able to accept a command.

Verification (WIDTH=8)
REQ-036 Bit ops: CLEAR_ALL, WRITE_BIT idx=5 val=1, TOGGLE_BIT idx=0, WRITE_BIT idx=5 val=0 -> bits goes 00000000, 00100000, 00100001, 00000001, with one update per consecutive cycle.
REQ-037 Load and scan: LOAD 8'b0001_0100, then SCAN idx=0 val=1 -> scan_done 4 cycles after acceptance, with scan_found=1 and scan_index=2.
REQ-038 Wrap-around: bits=8'b0000_0010, SCAN idx=6 val=1 -> wraps past 7 to 0 and 1; scan_index=1, scan_found=1, scan_done 5 cycles after acceptance.
REQ-039 Not found: bits=8'hFF, SCAN idx=3 val=0 -> scan_found=0, scan_index=3, scan_done 9 cycles after acceptance.
REQ-040 Busy ignore: during a scan, hold cmd_valid=1 with WRITE_BIT idx=0 val=1 -> bits unchanged until DONE, write accepted in the first cycle back in IDLE.
REQ-041 Reset mid-scan: assert rst_n=0 in the 3rd SCAN cycle -> bits=0, cmd_ready=1 and all scan outputs 0 with no clock edge, and no scan_done pulse.
